// File: rtl/fsk_pkg.sv
// Shared types and constants for the 4-tone FSK demodulator.
// Symbol classes are decided by half-period length in clk cycles.
package fsk_pkg;

    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int RUN_W = 5;

    localparam int HP00 = 2;
    localparam int HP01 = 4;
    localparam int HP10 = 8;
    localparam int HP11 = 16;

    // Class boundaries sit midway between adjacent nominal half-periods.
    localparam int BND_01 = (HP00 + HP01) / 2;
    localparam int BND_10 = (HP01 + HP10) / 2;
    localparam int BND_11 = (HP10 + HP11) / 2;

    function automatic sym_t classify(input logic [RUN_W-1:0] len);
        if (len < RUN_W'(BND_01)) begin
            return 2'b00;
        end else if (len < RUN_W'(BND_10)) begin
            return 2'b01;
        end else if (len < RUN_W'(BND_11)) begin
            return 2'b10;
        end else begin
            return 2'b11;
        end
    endfunction

endpackage

// File: rtl/fsk_period_meter.sv
// Input stage, edge detector and saturating half-period run counter.
// FSK_DEMOD_SYNC_EN inserts a 2-flop synchronizer ahead of the input register.
module fsk_period_meter
    import fsk_pkg::*;
#(
    parameter int TIMEOUT = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             din_i,
    output logic             edge_o,
    output logic [RUN_W-1:0] len_o,
    output logic             timeout_o
);

    logic             din_in;
    logic             din_s_q;
    logic             din_d_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

`ifdef FSK_DEMOD_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], din_i};
        end
    end

    assign din_in = sync_q[1];
`else
    assign din_in = din_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            din_s_q <= 1'b0;
            din_d_q <= 1'b0;
            run_q   <= '0;
        end else begin
            din_s_q <= din_in;
            din_d_q <= din_s_q;
            run_q   <= run_d;
        end
    end

    assign edge_o = din_s_q ^ din_d_q;

    always_comb begin
        run_d = run_q;
        if (edge_o) begin
            run_d = RUN_W'(1);
        end else if (run_q != '1) begin
            run_d = run_q + 1'b1;
        end
    end

    assign len_o = run_q;

    // Fires on the cycle the counter steps onto TIMEOUT; an edge overrides it.
    assign timeout_o = !edge_o && (run_d == RUN_W'(TIMEOUT));

endmodule

// File: rtl/fsk_demodulator.sv
// 4-tone FSK demodulator: classifies measured half-periods and debounces
// the symbol decision. Optional input synchronizer: FSK_DEMOD_SYNC_EN.
module fsk_demodulator
    import fsk_pkg::*;
#(
    parameter int LOCK_CNT = 2,
    parameter int TIMEOUT  = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic [1:0] dout,
    output logic       valid,
    output logic       sym_stb
);

    logic             edge_w;
    logic [RUN_W-1:0] len_w;
    logic             tmo_w;

    fsk_period_meter #(
        .TIMEOUT (TIMEOUT)
    ) u_meter (
        .clk_i     (clk),
        .rst_i     (reset),
        .din_i     (din),
        .edge_o    (edge_w),
        .len_o     (len_w),
        .timeout_o (tmo_w)
    );

    state_t     state_q, state_d;
    sym_t       cand_q, cand_d;
    logic [2:0] match_q, match_d;
    sym_t       dout_q, dout_d;
    logic       valid_q, valid_d;
    logic       stb_q, stb_d;

    sym_t       cls;
    logic [2:0] match_upd;
    logic       hit;

    assign cls       = classify(len_w);
    assign match_upd = (cls == cand_q) ? match_q + 3'd1 : 3'd1;
    assign hit       = (match_upd == 3'(LOCK_CNT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= 2'b00;
            match_q <= 3'd0;
            dout_q  <= 2'b00;
            valid_q <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            match_q <= match_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            stb_q   <= stb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tmo_w) begin
            state_d = IDLE;
        end else if (edge_w) begin
            case (state_q)
                IDLE:    state_d = ACQ;
                ACQ:     if (hit) state_d = LOCKED;
                LOCKED:  state_d = LOCKED;
                default: state_d = IDLE;
            endcase
        end
    end

    // A matching edge while locked re-arms the candidate, so only
    // consecutive deviant edges can move dout.
    always_comb begin
        cand_d  = cand_q;
        match_d = match_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        stb_d   = 1'b0;
        if (tmo_w) begin
            match_d = 3'd0;
            dout_d  = 2'b00;
            valid_d = 1'b0;
        end else if (edge_w) begin
            case (state_q)
                IDLE: begin
                    match_d = 3'd0;
                end
                ACQ: begin
                    cand_d  = cls;
                    match_d = match_upd;
                    if (hit) begin
                        dout_d  = cls;
                        valid_d = 1'b1;
                        stb_d   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (cls == dout_q) begin
                        cand_d = dout_q;
                    end else begin
                        cand_d  = cls;
                        match_d = match_upd;
                        if (hit) begin
                            dout_d = cls;
                            stb_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    match_d = 3'd0;
                end
            endcase
        end
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign sym_stb = stb_q;

endmodule

// File: tb/tb_fsk_demodulator.sv
// Directed bench for fsk_demodulator: lock, symbol switch, glitch rejection,
// timeout, async reset and class boundaries; strobe timing via expected queue.
module tb_fsk_demodulator;

    localparam int TIMEOUT = 24;
`ifdef FSK_DEMOD_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic [1:0] dout;
    logic       valid;
    logic       sym_stb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tog = 0;
    int tl = 0;
    int valid_low = 0;
    logic watch_valid = 1'b0;
    logic done = 1'b0;

    int         obs_cyc_q[$];
    logic [1:0] obs_sym_q[$];
    int         exp_cyc_q[$];
    logic [1:0] exp_q[$];

    fsk_demodulator #(
        .LOCK_CNT (2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .dout    (dout),
        .valid   (valid),
        .sym_stb (sym_stb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sym_stb === 1'b1) begin
            obs_cyc_q.push_back(cyc);
            obs_sym_q.push_back(dout);
        end
        if (watch_valid && valid !== 1'b1) valid_low++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half(input int p);
        din = ~din;
        last_tog = cyc;
        repeat (p) @(negedge clk);
    endtask

    task automatic exp_stb(input logic [1:0] s);
        exp_cyc_q.push_back(last_tog + 1 + LAT);
        exp_q.push_back(s);
    endtask

    task automatic check_stbs(input string tag);
        chk({tag, "_stb_count"}, obs_cyc_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_cyc_q.size() > 0) begin
            chk({tag, "_stb_cyc"}, obs_cyc_q.pop_front(), exp_cyc_q.pop_front());
            chk({tag, "_stb_sym"}, obs_sym_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        exp_cyc_q.delete();
        obs_cyc_q.delete();
        obs_sym_q.delete();
    endtask

    task automatic gap();
        repeat (40) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_stb", sym_stb, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // symbol 00: lock on the 3rd edge
        half(2); half(2);
        chk("t1_prelock_valid", valid, 0);
        half(2); exp_stb(2'b00);
        repeat (3) half(2);
        repeat (4) @(negedge clk);
        chk("t1_valid", valid, 1);
        chk("t1_dout", dout, 2'b00);
        check_stbs("t1");
        gap();
        chk("t1_tmo_valid", valid, 0);

        // 01 then 11 while locked
        half(4); half(4); half(4); exp_stb(2'b01); half(4);
        watch_valid = 1'b1;
        half(16);
        half(16);
        chk("t2_hold_dout", dout, 2'b01);
        half(16); exp_stb(2'b11);
        chk("t2_new_dout", dout, 2'b11);
        chk("t2_valid", valid, 1);
        watch_valid = 1'b0;
        chk("t2_valid_drops", valid_low, 0);
        check_stbs("t2");
        gap();

        // symbol 10 with isolated 2-cycle glitches
        half(8); half(8); half(8); exp_stb(2'b10); half(8);
        half(2);
        half(8);
        half(2);
        half(8);
        half(8);
        chk("t3_dout", dout, 2'b10);
        chk("t3_valid", valid, 1);
        check_stbs("t3");
        gap();

        // timeout after lock on 11, then fresh acquisition
        half(16); half(16); half(16); exp_stb(2'b11); half(16);
        tl = last_tog;
        repeat (LAT + 7) @(negedge clk);
        chk("t4_pre_tmo_valid", valid, 1);
        chk("t4_pre_tmo_dout", dout, 2'b11);
        chk("t4_pre_tmo_cyc", cyc, tl + LAT + 23);
        @(negedge clk);
        chk("t4_tmo_valid", valid, 0);
        chk("t4_tmo_dout", dout, 2'b00);
        check_stbs("t4a");
        repeat (20) @(negedge clk);
        half(16); half(16); half(16); exp_stb(2'b11);
        chk("t4_relock_valid", valid, 1);
        check_stbs("t4b");
        gap();

        // async reset mid-lock on 01
        half(4); half(4); half(4); exp_stb(2'b01); half(4); half(4);
        check_stbs("t5a");
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_valid", valid, 0);
        chk("t5_rst_dout", dout, 2'b00);
        chk("t5_rst_stb", sym_stb, 0);
        din = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        half(4); half(4);
        chk("t5_prelock_valid", valid, 0);
        half(4); exp_stb(2'b01); half(4);
        chk("t5_relock_valid", valid, 1);
        chk("t5_relock_dout", dout, 2'b01);
        check_stbs("t5b");
        gap();

        // boundary lengths 5,6,11,12 and 23 (edge beats timeout)
        half(5); half(5);
        half(6); exp_stb(2'b01);
        half(6);
        half(11); exp_stb(2'b10);
        half(11);
        half(12);
        half(12);
        half(23); exp_stb(2'b11);
        half(23);
        half(2);
        repeat (4) @(negedge clk);
        chk("t6_valid", valid, 1);
        chk("t6_dout", dout, 2'b11);
        check_stbs("t6");
        gap();
        chk("t6_tmo_valid", valid, 0);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL watchdog observed=timeout expected=completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
